ocm_avalon_master: RTL and testbench
====================================

# ocm_avalon_master

Avalon-MM initiator that drives the single-port on-chip memory slave (2-bit word address, 32-bit data, byte enables, clock enable) from a simple command/stream interface. It issues single-word or wrapping multi-word write and read sequences, honours `waitrequest` and a fixed read latency, and returns read data on a valid-qualified output. It sits between game-logic FSMs (sprite/state tables) and the OCM, replacing ad-hoc direct RAM pokes.

## Interface
- `ADDR_W`, 2, word-address width; also the width of `cmd_len`
- `DATA_W`, 32, data width; byte-enable width is `DATA_W/8`
- `READ_LATENCY`, 1, cycles from accepted read address to valid `avm_readdata`; legal 1..3
- `clk`  in  1  single clock, all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`
- `cmd_write`  in  1  1 = write sequence, 0 = read sequence
- `cmd_addr`  in  ADDR_W  first word address
- `cmd_len`  in  ADDR_W  word count minus 1 (0 = 1 word, 3 = 4 words)
- `cmd_byteenable`  in  DATA_W/8  byte enables for every write word; reads always use all-ones
- `wr_valid`  in  1  write-data word offered
- `wr_data`  in  DATA_W  write-data word
- `wr_ready`  out  1  word consumed when `wr_valid & wr_ready`
- `rd_valid`  out  1  one-cycle pulse, `rd_data` valid
- `rd_data`  out  DATA_W  read word, in address order
- `done`  out  1  one-cycle pulse, sequence complete
- `avm_address`  out  ADDR_W  word address
- `avm_chipselect`  out  1  transfer request
- `avm_write`  out  1  write qualifier
- `avm_byteenable`  out  DATA_W/8  byte lanes
- `avm_writedata`  out  DATA_W  write data
- `avm_readdata`  in  DATA_W  slave read data
- `avm_waitrequest`  in  1  slave stall; tie 0 for OCM
- `avm_clken`  out  1  slave clock enable; 1 whenever out of reset

## Operation
- States: IDLE, WR, RD_REQ, RD_WAIT, DONE.
- IDLE: `cmd_ready`=1. On accept, latch addr, len, byteenable, direction; go WR or RD_REQ.
- WR: `wr_ready` = `~avm_waitrequest` (combinational). `avm_chipselect`=`avm_write`=`wr_valid`; `avm_writedata`=`wr_data`, `avm_byteenable`=latched enables. Transfer completes on `wr_valid & ~avm_waitrequest`; then address+1, remaining−1. Last transfer -> DONE. No `wr_valid` -> bus idle (chipselect 0), stay.
- RD_REQ: `avm_chipselect`=1, `avm_write`=0, byteenable all-ones. Held while `avm_waitrequest`=1. When accepted -> RD_WAIT, latency counter loaded with READ_LATENCY−1.
- RD_WAIT: chipselect 0. When counter = 0: capture `avm_readdata` into `rd_data`, pulse `rd_valid` next cycle; address+1, remaining−1; back to RD_REQ, or DONE after last word.
- DONE: `done`=1 for one cycle, -> IDLE. `cmd_ready`=0 here.
- Address arithmetic modulo 2^ADDR_W: from 3, next is 0. `cmd_len` max = 2^ADDR_W−1, so a sequence never revisits a word.
- `wr_valid` ignored outside WR; `cmd_valid` ignored outside IDLE.
- Reset (any time, including mid-sequence): immediate return to IDLE, sequence abandoned, no `done`. Reset values: `cmd_ready`=1 after release (0 during reset), `wr_ready`=0, `rd_valid`=0, `rd_data`=0, `done`=0, `avm_address`=0, `avm_chipselect`=0, `avm_write`=0, `avm_byteenable`=0, `avm_writedata`=0, `avm_clken`=0 during reset, 1 after.

## Timing
- Command accept -> first bus request: 1 cycle.
- Write: 1 word per cycle with `wr_valid` held and no waitrequest; `done` the cycle after the last accepted word. N-word write = N+2 cycles from cmd accept to `done` inclusive.
- Read: per word 1 (RD_REQ) + READ_LATENCY cycles; `rd_valid` registered, in the first RD_REQ/DONE cycle after capture. `done` coincides with the last `rd_valid`.
- `avm_address`, `avm_chipselect`, `avm_write` are registered/state-decoded; `avm_writedata` and `avm_chipselect` in WR follow `wr_valid` combinationally.
- Waitrequest stalls hold all avm outputs stable.

## Test plan
- Single write: cmd addr=2, len=0, be=4'b1111, wr_data=0xDEADBEEF -> one cycle chipselect=write=1, address=2; `done` next cycle; subsequent read addr=2 returns 0xDEADBEEF.
- Wrapping burst write/read: write addr=3, len=3, data 0x11,0x22,0x33,0x44 -> addresses 3,0,1,2; read addr=0 len=3 -> `rd_data` 0x22,0x33,0x44,0x11, `done` with the fourth `rd_valid`.
- Byte enables: word 1 = 0xAABBCCDD, write 0x00000000 with be=4'b0101 -> read gives 0xAA00CC00.
- Backpressure: waitrequest high 3 cycles during RD_REQ and during WR; write data gapped by `wr_valid` low -> avm outputs stable while stalled, no duplicate/lost words, correct final contents.
- READ_LATENCY=3 build with delayed-data model -> data captured exactly 3 cycles after accepted request; 2-word read takes 8 cycles to `done`.
- Reset mid-burst: assert `reset_n`=0 after 2nd word of a 4-word write -> all outputs at reset values same cycle, no `done`; after release `cmd_ready`=1 and a new command executes normally.

Source files
------------

// File: rtl/ocm_avalon_master_if.sv
// Avalon-MM signals between the OCM initiator and the single-port on-chip memory.
interface ocm_avalon_master_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   avm_address;
    logic                avm_chipselect;
    logic                avm_write;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic [DATA_W-1:0]   avm_writedata;
    logic [DATA_W-1:0]   avm_readdata;
    logic                avm_waitrequest;
    logic                avm_clken;

    modport master (
        output avm_address, avm_chipselect, avm_write, avm_byteenable,
               avm_writedata, avm_clken,
        input  avm_readdata, avm_waitrequest
    );

    modport slave (
        input  avm_address, avm_chipselect, avm_write, avm_byteenable,
               avm_writedata, avm_clken,
        output avm_readdata, avm_waitrequest
    );
endinterface

// File: rtl/ocm_avalon_master.sv
// Avalon-MM initiator for the on-chip memory: turns single or wrapping
// multi-word commands into bus writes/reads with fixed read latency.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a command, cmd_ready high
// WR        | one bus write per accepted wr_valid word
// RD_REQ    | read request on the bus, held through waitrequest
// RD_WAIT   | counting down read latency, capture data at zero
// DONE      | one-cycle completion pulse
module ocm_avalon_master #(
    parameter int ADDR_W       = 2,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [ADDR_W-1:0]   cmd_len,
    input  logic [DATA_W/8-1:0] cmd_byteenable,
    input  logic                wr_valid,
    input  logic [DATA_W-1:0]   wr_data,
    output logic                wr_ready,
    output logic                rd_valid,
    output logic [DATA_W-1:0]   rd_data,
    output logic                done,
    ocm_avalon_master_if.master bus
);
    localparam int BE_W = DATA_W / 8;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR      = 3'd1;
    localparam logic [2:0] S_RD_REQ  = 3'd2;
    localparam logic [2:0] S_RD_WAIT = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [1:0] LAT_LOAD = 2'(READ_LATENCY - 1);

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] remain_q;
    logic [BE_W-1:0]   be_q;
    logic [1:0]        lat_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            remain_q   <= '0;
            be_q       <= '0;
            lat_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        addr_q   <= cmd_addr;
                        remain_q <= cmd_len;
                        be_q     <= cmd_byteenable;
                        state    <= cmd_write ? S_WR : S_RD_REQ;
                    end
                end
                S_WR: begin
                    if (wr_valid && !bus.avm_waitrequest) begin
                        addr_q   <= addr_q + 1'b1;
                        remain_q <= remain_q - 1'b1;
                        if (remain_q == '0)
                            state <= S_DONE;
                    end
                end
                S_RD_REQ: begin
                    if (!bus.avm_waitrequest) begin
                        lat_q <= LAT_LOAD;
                        state <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (lat_q == 2'd0) begin
                        rd_data_q  <= bus.avm_readdata;
                        rd_valid_q <= 1'b1;
                        addr_q     <= addr_q + 1'b1;
                        remain_q   <= remain_q - 1'b1;
                        state      <= (remain_q == '0) ? S_DONE : S_RD_REQ;
                    end else begin
                        lat_q <= lat_q - 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Write strobes track wr_valid directly so a gapped stream leaves the bus idle.
    always_comb begin
        bus.avm_chipselect = 1'b0;
        bus.avm_write      = 1'b0;
        bus.avm_byteenable = '0;
        bus.avm_writedata  = '0;
        wr_ready           = 1'b0;
        case (state)
            S_WR: begin
                bus.avm_chipselect = wr_valid;
                bus.avm_write      = wr_valid;
                bus.avm_byteenable = be_q;
                bus.avm_writedata  = wr_data;
                wr_ready           = ~bus.avm_waitrequest;
            end
            S_RD_REQ: begin
                bus.avm_chipselect = 1'b1;
                bus.avm_byteenable = '1;
            end
            default: ;
        endcase
    end

    assign bus.avm_address = addr_q;
    assign bus.avm_clken   = reset_n;
    assign cmd_ready       = reset_n & (state == S_IDLE);
    assign done            = (state == S_DONE);
    assign rd_valid        = rd_valid_q;
    assign rd_data         = rd_data_q;
endmodule

// File: tb/tb_ocm_avalon_master.sv
// Directed bench for ocm_avalon_master against a word-level memory model.
module tb_ocm_avalon_master;
    localparam int RL = 3;

    typedef struct packed {
        logic [1:0]  a;
        logic        w;
        logic [3:0]  be;
        logic [31:0] d;
    } xfer_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [1:0]  cmd_addr, cmd_len;
    logic [3:0]  cmd_byteenable;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        done;
    logic        waitreq;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ocm_avalon_master_if #(.ADDR_W(2), .DATA_W(32)) bus ();

    ocm_avalon_master #(.ADDR_W(2), .DATA_W(32), .READ_LATENCY(RL)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_byteenable(cmd_byteenable),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .done(done),
        .bus(bus)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = be[b] ? nw[8*b +: 8] : old[8*b +: 8];
        return r;
    endfunction

    // Slave memory with RL-deep read data pipeline
    logic [31:0] ram [4] = '{default: 32'h0};
    logic [31:0] pipe [RL] = '{default: 32'h0};
    assign bus.avm_waitrequest = waitreq;
    assign bus.avm_readdata    = pipe[RL-1];

    always @(posedge clk) begin
        if (bus.avm_chipselect && !waitreq && bus.avm_write)
            ram[bus.avm_address] <= merge(ram[bus.avm_address], bus.avm_writedata, bus.avm_byteenable);
        pipe[0] <= (bus.avm_chipselect && !waitreq && !bus.avm_write) ? ram[bus.avm_address] : 32'hBAD0BAD0;
        for (int i = 1; i < RL; i++)
            pipe[i] <= pipe[i-1];
    end

    // Reference model: expected memory, expected bus transfers, expected read words
    logic [31:0] mem_exp [4] = '{default: 32'h0};
    xfer_t       exp_xfer [$];
    logic [31:0] exp_rd [$];
    logic [31:0] got [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic        prev_stall = 1'b0;
    logic        prev_done = 1'b0;
    logic [39:0] prev_bus;
    logic [39:0] cur_bus;
    xfer_t       cx;
    logic [31:0] ce;

    assign cur_bus = {bus.avm_chipselect, bus.avm_address, bus.avm_write,
                      bus.avm_byteenable, bus.avm_writedata};

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            chk("clken", bus.avm_clken, 1);
            if (prev_stall)
                chk("stall_hold", cur_bus, prev_bus);
            if (rd_valid) begin
                chk("rd_pending", exp_rd.size() != 0, 1);
                if (exp_rd.size() != 0) begin
                    ce = exp_rd.pop_front();
                    chk("rd_data", rd_data, ce);
                    got.push_back(rd_data);
                end
            end
            if (bus.avm_chipselect && !waitreq) begin
                chk("xfer_pending", exp_xfer.size() != 0, 1);
                if (exp_xfer.size() != 0) begin
                    cx = exp_xfer.pop_front();
                    chk("xfer_addr", bus.avm_address, cx.a);
                    chk("xfer_write", bus.avm_write, cx.w);
                    chk("xfer_be", bus.avm_byteenable, cx.be);
                    if (cx.w)
                        chk("xfer_wdata", bus.avm_writedata, cx.d);
                end
            end
            if (done) begin
                chk("done_pulse", prev_done, 0);
                chk("done_leftover", exp_xfer.size() + exp_rd.size(), 0);
            end
            prev_stall = bus.avm_chipselect & waitreq;
            prev_bus   = cur_bus;
            prev_done  = done;
        end
    end

    task automatic reset_outs(input string tag);
        chk({tag, "_cmd_ready"}, cmd_ready, 0);
        chk({tag, "_wr_ready"}, wr_ready, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_bus"}, cur_bus, 0);
        chk({tag, "_clken"}, bus.avm_clken, 0);
    endtask

    // One command; stall/gap masks index cycles after the accept edge.
    task automatic run(input bit wr, input logic [1:0] a, input logic [1:0] l, input logic [3:0] be,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] d3, input logic [31:0] stall, input logic [31:0] gap,
                       input int exp_done, input int rst_at);
        logic [31:0] wd [4];
        logic [1:0]  ad;
        xfer_t       x;
        int          n, k;
        bit          acc, seen;
        wd = '{d0, d1, d2, d3};
        n  = int'(l) + 1;
        for (int i = 0; i < n; i++) begin
            if (rst_at >= 0 && i >= rst_at) break;
            ad = a + 2'(i);
            x.a = ad; x.w = wr; x.be = wr ? be : 4'hF; x.d = wr ? wd[i] : 32'h0;
            exp_xfer.push_back(x);
            if (wr) mem_exp[ad] = merge(mem_exp[ad], wd[i], be);
            else    exp_rd.push_back(mem_exp[ad]);
        end
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = l; cmd_byteenable = be;
        @(negedge clk);
        chk("cmd_ready", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        k = 0;
        seen = 1'b0;
        for (int c = 0; c < 32 && !seen; c++) begin
            waitreq  = stall[c];
            wr_valid = wr && (k < n) && !gap[c];
            wr_data  = (k < n) ? wd[k] : 32'h0;
            if (rst_at >= 0 && c == rst_at) begin
                reset_n = 1'b0;
                #1;
                reset_outs("rst_mid");
                exp_xfer.delete();
                exp_rd.delete();
                wr_valid = 1'b0;
                waitreq  = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    chk("rst_no_done", done, 0);
                end
                @(posedge clk); #1;
                reset_n = 1'b1;
                #1;
                chk("rst_release_ready", cmd_ready, 1);
                return;
            end
            @(negedge clk);
            acc  = wr_valid & wr_ready;
            seen = done;
            if (done) begin
                chk("done_cycle", c, exp_done);
                chk("done_rd_valid", rd_valid, !wr);
            end
            @(posedge clk); #1;
            if (acc) k++;
        end
        chk("done_seen", seen, 1);
        wr_valid = 1'b0;
        waitreq  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    initial begin
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0; cmd_byteenable = 0;
        wr_valid = 0; wr_data = 0; waitreq = 0;
        repeat (3) @(posedge clk);
        #1;
        reset_outs("rst_init");
        reset_n = 1'b1;
        #1;
        chk("init_ready", cmd_ready, 1);
        chk("init_clken", bus.avm_clken, 1);

        // single write then read back
        run(1, 2'd2, 2'd0, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1, -1);
        run(0, 2'd2, 2'd0, 4'hF, 0, 0, 0, 0, 0, 0, 1 * (1 + RL), -1);
        chk("lit_deadbeef", got[got.size()-1], 32'hDEADBEEF);

        // wrapping burst
        run(1, 2'd3, 2'd3, 4'hF, 32'h11, 32'h22, 32'h33, 32'h44, 0, 0, 4, -1);
        run(0, 2'd0, 2'd3, 4'hF, 0, 0, 0, 0, 0, 0, 4 * (1 + RL), -1);
        chk("lit_wrap0", got[got.size()-4], 32'h22);
        chk("lit_wrap1", got[got.size()-3], 32'h33);
        chk("lit_wrap2", got[got.size()-2], 32'h44);
        chk("lit_wrap3", got[got.size()-1], 32'h11);

        // byte enables
        run(1, 2'd1, 2'd0, 4'hF, 32'hAABBCCDD, 0, 0, 0, 0, 0, 1, -1);
        run(1, 2'd1, 2'd0, 4'b0101, 32'h00000000, 0, 0, 0, 0, 0, 1, -1);
        run(0, 2'd1, 2'd0, 4'hF, 0, 0, 0, 0, 0, 0, 4, -1);
        chk("lit_byteen", got[got.size()-1], 32'hAA00CC00);

        // backpressure: 3 stall cycles plus a 2-cycle wr_valid gap, then stalled read
        run(1, 2'd0, 2'd3, 4'hF, 32'h1, 32'h2, 32'h3, 32'h4, 32'h0000_000E, 32'h0000_0060, 9, -1);
        run(0, 2'd0, 2'd3, 4'hF, 0, 0, 0, 0, 32'h0000_0007, 0, 19, -1);
        chk("lit_bp0", got[got.size()-4], 32'h1);
        chk("lit_bp3", got[got.size()-1], 32'h4);

        // two-word read at latency 3: done on cycle 8
        run(0, 2'd2, 2'd1, 4'hF, 0, 0, 0, 0, 0, 0, 8, -1);

        // reset after the second word of a 4-word write, then normal operation
        run(1, 2'd0, 2'd3, 4'hF, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 0, 0, 0, 2);
        run(0, 2'd0, 2'd3, 4'hF, 0, 0, 0, 0, 0, 0, 16, -1);
        chk("lit_rst0", got[got.size()-4], 32'hA0);
        chk("lit_rst2", got[got.size()-2], 32'h3);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
